msg_rx_pkt_framer: RTL and testbench
====================================

# msg_rx_pkt_framer

Downstream stage of the 4-lane message receiver. It consumes the received byte stream (one byte per valid pulse), hunts for the message frame header and checks the length and checksum. Good payloads go into a single-frame packet buffer. The Ethernet/UDP transmit path reads each committed frame out of the buffer with a known byte count, so a packet is only offered after it is complete and verified.

## Interface
Parameters:
- MAX_LEN, 1024: maximum payload bytes per frame; also the buffer depth.
- TIMEOUT_CYC, 4096: maximum idle clk cycles between two bytes inside a frame.
- HDR0, 8'hA5: first header byte.
- HDR1, 8'h5A: second header byte.

Ports:
- clk  in  1  receiver clock; the same clock that drives the byte stream.
- rst  in  1  synchronous, active-high reset.
- msg_rx_data_vld_i  in  1  one-cycle strobe per received byte.
- msg_rx_data_i  in  8  received byte, valid with the strobe.
- pkt_rdy_o  out  1  a verified frame is held in the buffer.
- pkt_len_o  out  16  payload byte count of the held frame; stable while pkt_rdy_o is high.
- pkt_rd_en_i  in  1  read request, one byte per cycle.
- pkt_data_vld_o  out  1  read data valid.
- pkt_data_o  out  8  read data byte.
- frame_ok_cnt_o  out  16  frames committed, saturating.
- frame_err_cnt_o  out  16  length, checksum or timeout failures, saturating.
- frame_drop_cnt_o  out  16  good frames discarded because the buffer was busy, saturating.

## Operation
- Frame format: HDR0, HDR1, LEN_H, LEN_L, payload[LEN], CHK.
  - CHK is the XOR of LEN_H, LEN_L and every payload byte.
- States: IDLE → HDR1 → LEN_H → LEN_L → PAYLOAD → CHK → IDLE. Each state advances only on a valid byte.
- IDLE: a byte equal to HDR0 moves to HDR1; any other byte is ignored.
- HDR1: a byte equal to HDR1 moves to LEN_H.
  - A byte equal to HDR0 stays in HDR1.
  - Any other byte returns to IDLE.
  - No counter changes in any of these header-hunt cases.
- LEN_L: length is LEN = {LEN_H, LEN_L}.
  - If LEN is 0 or greater than MAX_LEN: frame_err_cnt +1, go to IDLE.
  - Otherwise latch a write-enable flag (`own`) equal to !pkt_rdy_o. Buffer ownership is decided here, once per frame.
- PAYLOAD: each byte is written to buffer[wr_ptr] when own=1, and XOR-accumulated. After LEN bytes, move to CHK.
- CHK: compare the received byte with the XOR accumulator.
  - Mismatch: frame_err_cnt +1.
  - Match and own=1: commit (pkt_len_o ← LEN, pkt_rdy_o ← 1, frame_ok_cnt +1).
  - Match and own=0: frame_drop_cnt +1.
  - All three cases return to IDLE.
- Timeout: in any state other than IDLE, if TIMEOUT_CYC cycles pass without a valid byte: frame_err_cnt +1, go to IDLE. Nothing is committed.
- Read side:
  - pkt_rd_en_i is honoured only while pkt_rdy_o=1 and rd_ptr < pkt_len_o. Otherwise it is ignored.
  - Each accepted read returns buffer[rd_ptr] and increments rd_ptr.
  - The accepted read of the last byte clears pkt_rdy_o and rd_ptr on the next edge. The buffer is free from that point.
- Counters saturate at 16'hFFFF. They clear only on reset.

## Timing
- Reset values: pkt_rdy_o=0, pkt_len_o=0, pkt_data_vld_o=0, pkt_data_o=0, all counters 0, FSM in IDLE, pointers 0.
- Commit latency: pkt_rdy_o rises one cycle after the CHK byte strobe.
- Read latency: pkt_data_vld_o and pkt_data_o are registered one cycle after an accepted pkt_rd_en_i. The buffer read is synchronous (block RAM).
- Back-to-back reads: LEN consecutive pkt_rd_en_i cycles give LEN consecutive valid bytes. pkt_rdy_o is low from the cycle after the last accepted read.
- Simultaneous events:
  - LEN_L accepted in the same cycle as the final read: own is computed from the current pkt_rdy_o (still 1), so the frame is dropped. This is deterministic.
  - Buffer write and read in the same cycle cannot collide, because a frame is only written when own=1, i.e. when no frame is being held or read.
- Timeout counter:
  - Cleared on every valid byte and in IDLE.
  - Fires on the cycle its count reaches TIMEOUT_CYC-1 with no strobe.
  - A strobe in that same cycle wins; no timeout occurs.
- Reset mid-frame or mid-read: everything returns to reset values. A partially written or partially read frame is lost.

## Structure
- Shared package msg_pkg holds:
  - HDR0/HDR1 defaults;
  - the state encoding (IDLE, HDR1, LEN_H, LEN_L, PAYLOAD, CHK);
  - the 16-bit counter width;
  - a saturating-increment function.
  - The transmit framer uses the same package.
- One sub-module: msg_pkt_ram, a simple dual-port RAM, MAX_LEN×8, with a write port and a registered read port on clk.
- The parser FSM, checksum, timeout logic and read control live in the top level.

## Test plan
- Good frame A5 5A 00 03 11 22 33 CHK=00^03^11^22^33=03 → pkt_rdy_o=1, pkt_len_o=3. Then three reads → 11, 22, 33 with a 1-cycle latency, pkt_rdy_o=0, frame_ok_cnt=1.
- Same frame with CHK=04 → no pkt_rdy_o, frame_err_cnt=1.
- LEN=0, then LEN=MAX_LEN+1 → frame_err_cnt=2, nothing committed. Then LEN=MAX_LEN with a valid CHK → commit, full read-back matches.
- Frame held unread, second good frame arrives → frame_drop_cnt=1. First frame reads back intact.
- Garbage A5 A5 5A 00 01 77 76 → the header resyncs on the second A5 and the frame commits with byte 77.
- Gap of TIMEOUT_CYC cycles after byte 2 of the payload → frame_err_cnt=1, FSM in IDLE. Next frame accepted. Also check that assertion of rst mid-read clears pkt_rdy_o the next cycle.

Source files
------------

// File: rtl/msg_pkg.sv
// msg_pkg: shared header bytes, parser states, counter width and saturating increment
package msg_pkg;
  localparam logic [7:0] HDR0_DEF = 8'hA5;
  localparam logic [7:0] HDR1_DEF = 8'h5A;
  localparam int CNT_W = 16;
  typedef enum logic [2:0] {ST_IDLE, ST_HDR1, ST_LEN_H, ST_LEN_L, ST_PAYLOAD, ST_CHK} msg_state_e;
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return &v ? v : v + 1'b1;
  endfunction
endpackage

// File: rtl/msg_pkt_ram.sv
// msg_pkt_ram: simple dual-port byte RAM with a registered read port
module msg_pkt_ram #(
  parameter int DEPTH = 1024,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] wa,
  input  logic [7:0]    wd,
  input  logic          re,
  input  logic [AW-1:0] ra,
  output logic [7:0]    rd
);
  logic [7:0] mem [DEPTH];
  // write port
  always_ff @(posedge clk)
    if (we) mem[wa] <= wd;
  // registered read port, cleared on reset so the output starts at zero
  always_ff @(posedge clk)
    if (rst) rd <= '0;
    else if (re) rd <= mem[ra];
endmodule

// File: rtl/msg_rx_pkt_framer.sv
// msg_rx_pkt_framer: parses, verifies and buffers one received message frame for readout
module msg_rx_pkt_framer
  import msg_pkg::*;
#(
  parameter int MAX_LEN = 1024,
  parameter int TIMEOUT_CYC = 4096,
  parameter logic [7:0] HDR0 = HDR0_DEF,
  parameter logic [7:0] HDR1 = HDR1_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             msg_rx_data_vld_i,
  input  logic [7:0]       msg_rx_data_i,
  output logic             pkt_rdy_o,
  output logic [15:0]      pkt_len_o,
  input  logic             pkt_rd_en_i,
  output logic             pkt_data_vld_o,
  output logic [7:0]       pkt_data_o,
  output logic [CNT_W-1:0] frame_ok_cnt_o,
  output logic [CNT_W-1:0] frame_err_cnt_o,
  output logic [CNT_W-1:0] frame_drop_cnt_o
);
  localparam int AW = $clog2(MAX_LEN);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [15:0] MAX_L = 16'(MAX_LEN);
  msg_state_e state, state_n;
  logic [7:0] len_h, acc;
  logic [15:0] len, wr_cnt, rd_ptr, len_n;
  logic [TW-1:0] tmo;
  logic own, vld, len_bad, tmo_fire, err_ev, ok_ev, drop_ev, rd_acc, rd_last;
  assign vld = msg_rx_data_vld_i;
  assign len_n = {len_h, msg_rx_data_i};
  assign len_bad = len_n == 16'd0 || len_n > MAX_L;
  assign tmo_fire = state != ST_IDLE && !vld && tmo == TW'(TIMEOUT_CYC - 1);
  assign rd_acc = pkt_rd_en_i && pkt_rdy_o && rd_ptr < pkt_len_o;
  assign rd_last = rd_acc && rd_ptr == pkt_len_o - 16'd1;
  // next state and per-frame outcome events
  always_comb begin
    state_n = state;
    err_ev = 1'b0;
    ok_ev = 1'b0;
    drop_ev = 1'b0;
    if (tmo_fire) begin
      state_n = ST_IDLE;
      err_ev = 1'b1;
    end else if (vld) begin
      case (state)
        ST_IDLE:    state_n = msg_rx_data_i == HDR0 ? ST_HDR1 : ST_IDLE;
        ST_HDR1:    state_n = msg_rx_data_i == HDR1 ? ST_LEN_H : msg_rx_data_i == HDR0 ? ST_HDR1 : ST_IDLE;
        ST_LEN_H:   state_n = ST_LEN_L;
        ST_LEN_L: begin
          state_n = len_bad ? ST_IDLE : ST_PAYLOAD;
          err_ev = len_bad;
        end
        ST_PAYLOAD: state_n = wr_cnt == len - 16'd1 ? ST_CHK : ST_PAYLOAD;
        ST_CHK: begin
          state_n = ST_IDLE;
          err_ev = msg_rx_data_i != acc;
          ok_ev = msg_rx_data_i == acc && own;
          drop_ev = msg_rx_data_i == acc && !own;
        end
        default:    state_n = ST_IDLE;
      endcase
    end
  end
  // parser state, length/checksum capture, byte counter and idle timer
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      tmo <= '0;
      len_h <= '0;
      len <= '0;
      acc <= '0;
      own <= 1'b0;
      wr_cnt <= '0;
    end else begin
      state <= state_n;
      tmo <= vld || state == ST_IDLE ? '0 : tmo + 1'b1;
      if (vld && state == ST_LEN_H) len_h <= msg_rx_data_i;
      if (vld) acc <= state == ST_LEN_H ? msg_rx_data_i : acc ^ msg_rx_data_i;
      if (vld && state == ST_LEN_L) begin
        len <= len_n;
        own <= !pkt_rdy_o;
      end
      if (vld) wr_cnt <= state == ST_PAYLOAD ? wr_cnt + 16'd1 : '0;
    end
  end
  // held-frame handshake, read pointer and statistics counters
  always_ff @(posedge clk) begin
    if (rst) begin
      pkt_rdy_o <= 1'b0;
      pkt_len_o <= '0;
      rd_ptr <= '0;
      pkt_data_vld_o <= 1'b0;
      frame_ok_cnt_o <= '0;
      frame_err_cnt_o <= '0;
      frame_drop_cnt_o <= '0;
    end else begin
      pkt_rdy_o <= ok_ev ? 1'b1 : rd_last ? 1'b0 : pkt_rdy_o;
      if (ok_ev) pkt_len_o <= len;
      rd_ptr <= rd_last ? '0 : rd_acc ? rd_ptr + 16'd1 : rd_ptr;
      pkt_data_vld_o <= rd_acc;
      if (ok_ev) frame_ok_cnt_o <= sat_inc(frame_ok_cnt_o);
      if (err_ev) frame_err_cnt_o <= sat_inc(frame_err_cnt_o);
      if (drop_ev) frame_drop_cnt_o <= sat_inc(frame_drop_cnt_o);
    end
  end
  msg_pkt_ram #(.DEPTH(MAX_LEN), .AW(AW)) u_ram (
    .clk(clk),
    .rst(rst),
    .we(vld && state == ST_PAYLOAD && own),
    .wa(wr_cnt[AW-1:0]),
    .wd(msg_rx_data_i),
    .re(rd_acc),
    .ra(rd_ptr[AW-1:0]),
    .rd(pkt_data_o)
  );
endmodule

// File: tb/tb_msg_rx_pkt_framer.sv
// tb_msg_rx_pkt_framer: directed frames with a queue scoreboard on the read port
module tb_msg_rx_pkt_framer;
  localparam int MAX_LEN = 16;
  localparam int TMO = 64;
  logic clk = 1'b0, rst = 1'b1, vld = 1'b0, rd_en = 1'b0;
  logic [7:0] din = '0;
  logic pkt_rdy, pkt_dvld;
  logic [15:0] pkt_len, ok_cnt, err_cnt, drop_cnt;
  logic [7:0] pkt_data, exp_b;
  int checks = 0, errors = 0;
  logic [7:0] exp_q[$];
  logic [7:0] held[$];
  logic [7:0] pl[$];
  msg_rx_pkt_framer #(.MAX_LEN(MAX_LEN), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk),
    .rst(rst),
    .msg_rx_data_vld_i(vld),
    .msg_rx_data_i(din),
    .pkt_rdy_o(pkt_rdy),
    .pkt_len_o(pkt_len),
    .pkt_rd_en_i(rd_en),
    .pkt_data_vld_o(pkt_dvld),
    .pkt_data_o(pkt_data),
    .frame_ok_cnt_o(ok_cnt),
    .frame_err_cnt_o(err_cnt),
    .frame_drop_cnt_o(drop_cnt)
  );
  always #5 clk = ~clk;
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic send(input logic [7:0] b);
    vld = 1'b1;
    din = b;
    @(posedge clk);
    #1;
    vld = 1'b0;
  endtask
  task automatic idle(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask
  task automatic send_frame(input logic bad);
    logic [15:0] l;
    logic [7:0] c;
    l = 16'(pl.size());
    send(8'hA5);
    send(8'h5A);
    send(l[15:8]);
    send(l[7:0]);
    c = l[15:8] ^ l[7:0];
    foreach (pl[i]) begin
      send(pl[i]);
      c = c ^ pl[i];
    end
    send(bad ? c + 8'd1 : c);
  endtask
  task automatic read_n(input int n);
    for (int i = 0; i < n; i++) begin
      rd_en = 1'b1;
      if (i < held.size()) exp_q.push_back(held[i]);
      @(posedge clk);
      #1;
    end
    rd_en = 1'b0;
    if (n >= held.size()) held.delete();
    idle(2);
  endtask
  // scoreboard monitor: every valid read byte must match the oldest expected byte
  always @(negedge clk) begin
    if (!rst && pkt_dvld) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rd_data: unexpected byte %0h with nothing expected", pkt_data);
      end else begin
        exp_b = exp_q.pop_front();
        check("rd_data", {24'd0, pkt_data}, {24'd0, exp_b});
      end
    end
  end
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    idle(3);
    rst = 1'b0;
    check("rst_rdy", pkt_rdy, 0);
    check("rst_len", pkt_len, 0);
    check("rst_dvld", pkt_dvld, 0);
    check("rst_data", pkt_data, 0);
    check("rst_ok", ok_cnt, 0);
    check("rst_err", err_cnt, 0);
    check("rst_drop", drop_cnt, 0);
    pl = '{8'h11, 8'h22, 8'h33};
    send_frame(1'b0);
    check("a_rdy", pkt_rdy, 1);
    check("a_len", pkt_len, 3);
    held = pl;
    read_n(3);
    check("a_rdy_after", pkt_rdy, 0);
    check("a_ok", ok_cnt, 1);
    read_n(2);
    send_frame(1'b1);
    check("badchk_rdy", pkt_rdy, 0);
    check("badchk_err", err_cnt, 1);
    check("badchk_ok", ok_cnt, 1);
    send(8'hA5); send(8'h5A); send(8'h00); send(8'h00);
    check("len0_err", err_cnt, 2);
    send(8'hA5); send(8'h5A); send(8'h00); send(8'(MAX_LEN + 1));
    check("lenbig_err", err_cnt, 3);
    check("lenbig_rdy", pkt_rdy, 0);
    pl.delete();
    for (int i = 0; i < MAX_LEN; i++) pl.push_back(8'(i * 7 + 1));
    send_frame(1'b0);
    check("max_rdy", pkt_rdy, 1);
    check("max_len", pkt_len, MAX_LEN);
    held = pl;
    read_n(MAX_LEN);
    check("max_rdy_after", pkt_rdy, 0);
    check("max_ok", ok_cnt, 2);
    pl = '{8'hAA, 8'hBB};
    send_frame(1'b0);
    held = pl;
    pl = '{8'hCC};
    send_frame(1'b0);
    check("drop_cnt", drop_cnt, 1);
    check("drop_ok", ok_cnt, 3);
    check("drop_len", pkt_len, 2);
    read_n(2);
    send(8'hA5); send(8'hA5); send(8'h5A); send(8'h00); send(8'h01); send(8'h77); send(8'h76);
    check("resync_rdy", pkt_rdy, 1);
    check("resync_len", pkt_len, 1);
    check("resync_ok", ok_cnt, 4);
    held = '{8'h77};
    read_n(1);
    send(8'hA5); send(8'h5A); send(8'h00); send(8'h04); send(8'h01); send(8'h02);
    idle(TMO);
    check("tmo_err", err_cnt, 4);
    check("tmo_rdy", pkt_rdy, 0);
    send(8'hA5); send(8'h5A); send(8'h00); send(8'h02); send(8'h09);
    idle(TMO - 1);
    send(8'h0A);
    send(8'h01);
    check("edge_err", err_cnt, 4);
    check("edge_rdy", pkt_rdy, 1);
    check("edge_len", pkt_len, 2);
    check("edge_ok", ok_cnt, 5);
    held = '{8'h09, 8'h0A};
    read_n(2);
    pl = '{8'h31, 8'h32, 8'h33};
    send_frame(1'b0);
    held = pl;
    read_n(1);
    check("midrd_rdy", pkt_rdy, 1);
    rst = 1'b1;
    idle(1);
    check("midrd_rst_rdy", pkt_rdy, 0);
    check("midrd_rst_len", pkt_len, 0);
    check("midrd_rst_ok", ok_cnt, 0);
    check("midrd_rst_err", err_cnt, 0);
    rst = 1'b0;
    held.delete();
    idle(2);
    check("queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
